// File: rtl/fact_inverse.sv
// Sequential inverse factorial: finds the largest N with N! <= facto, one multiply per clock.
// Start/done handshake; also flags whether N! equals the captured operand exactly.
module fact_inverse (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] facto,
  output logic        busy,
  output logic        done,
  output logic [5:0]  N,
  output logic        exact
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t      state_q;
  logic [63:0] val_q;
  logic [5:0]  k_q;
  logic [63:0] prod_q;
  logic [5:0]  n_q;
  logic        exact_q;
  logic        busy_q;
  logic        done_q;

  logic [69:0] prod_d;
  logic        stop;

  // Full-width product, so a multiply that overflows 64 bits counts as exceeding val.
  always_comb begin
    prod_d = 70'(prod_q) * 70'(k_q + 6'd1);
    stop   = (|prod_d[69:64]) || (prod_d[63:0] > val_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      val_q   <= '0;
      k_q     <= '0;
      prod_q  <= '0;
      n_q     <= '0;
      exact_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          if (start) begin
            val_q <= facto;
            if (facto == '0) begin
              n_q     <= '0;
              exact_q <= 1'b0;
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              k_q     <= 6'd1;
              prod_q  <= 64'd1;
              state_q <= S_RUN;
              busy_q  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (stop) begin
            n_q     <= k_q;
            exact_q <= (prod_q == val_q);
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            prod_q <= prod_d[63:0];
            k_q    <= k_q + 6'd1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign N     = n_q;
  assign exact = exact_q;

endmodule

// File: tb/tb_fact_inverse.sv
// Bench for fact_inverse: directed and random requests against a factorial-table reference.
module tb_fact_inverse;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [63:0] facto;
  logic        busy;
  logic        done;
  logic [5:0]  N;
  logic        exact;

  int vectors    = 0;
  int miscompares = 0;

  logic [127:0] fact [0:21];

  fact_inverse dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .facto (facto),
    .busy  (busy),
    .done  (done),
    .N     (N),
    .exact (exact)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Largest n >= 1 with n! <= v, searched over a table of exact factorials.
  task automatic ref_model(input logic [63:0] v, output int n, output bit ex);
    n  = 0;
    ex = 1'b0;
    for (int i = 1; i <= 21; i++)
      if (fact[i] <= {64'd0, v}) n = i;
    if (n != 0) ex = (fact[n] == {64'd0, v});
  endtask

  // Issue one request from IDLE; optionally poke facto/start during a RUN cycle.
  task automatic run_req(input string tag, input logic [63:0] f, input int poke,
                         input logic [63:0] pv);
    int n_exp;
    bit ex_exp;
    int edges;
    int busy_cnt;
    bit seen;
    ref_model(f, n_exp, ex_exp);
    facto = f;
    start = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    edges    = 1;
    busy_cnt = 0;
    seen     = 1'b0;
    while (!seen && edges <= 30) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        if (busy) busy_cnt++;
        if (poke != 0 && busy_cnt == poke) begin
          facto = pv;
          start = 1'b1;
        end else begin
          start = 1'b0;
        end
        @(posedge clk); #1;
        edges++;
      end
    end
    start = 1'b0;
    chk({tag, " done_seen"}, 64'(seen), 64'd1);
    chk({tag, " latency"}, 64'(edges), 64'(n_exp + 1));
    chk({tag, " busy_cycles"}, 64'(busy_cnt), 64'(n_exp));
    chk({tag, " N"}, 64'(N), 64'(n_exp));
    chk({tag, " exact"}, 64'(exact), 64'(ex_exp));
    @(posedge clk); #1;
    chk({tag, " done_pulse"}, 64'(done), 64'd0);
    chk({tag, " N_hold"}, 64'(N), 64'(n_exp));
  endtask

  initial begin
    logic [63:0] r;
    int          idx;
    int          dn_edges [$];
    int          e;
    bit          bad;

    fact[0] = 128'd1;
    for (int i = 1; i <= 21; i++) fact[i] = fact[i-1] * 128'(i);

    rst   = 1'b1;
    start = 1'b0;
    facto = '0;
    #12;
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset N", 64'(N), 64'd0);
    chk("reset exact", 64'(exact), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_req("f120", 64'd120, 0, '0);
    run_req("f100", 64'd100, 0, '0);
    run_req("f1", 64'd1, 0, '0);
    run_req("f0", 64'd0, 0, '0);
    run_req("f20fact", 64'd2432902008176640000, 0, '0);
    run_req("fmax", 64'hFFFF_FFFF_FFFF_FFFF, 0, '0);
    run_req("f2", 64'd2, 0, '0);
    run_req("f21fact_lo", 64'd2432902008176639999, 0, '0);
    run_req("f720_poke", 64'd720, 2, 64'd6);

    // Start held high: results every N+2 edges.
    facto = 64'd120;
    start = 1'b1;
    e = 0;
    dn_edges.delete();
    while (dn_edges.size() < 3 && e < 60) begin
      @(posedge clk); #1;
      e++;
      if (done) begin
        dn_edges.push_back(e);
        chk("b2b N", 64'(N), 64'd5);
        chk("b2b exact", 64'(exact), 64'd1);
      end
    end
    start = 1'b0;
    chk("b2b count", 64'(dn_edges.size()), 64'd3);
    if (dn_edges.size() == 3) begin
      chk("b2b first", 64'(dn_edges[0]), 64'd6);
      chk("b2b gap1", 64'(dn_edges[1] - dn_edges[0]), 64'd7);
      chk("b2b gap2", 64'(dn_edges[2] - dn_edges[1]), 64'd7);
    end
    @(posedge clk); #1;

    // Asynchronous reset in RUN cycle 3.
    facto = 64'd5040;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst busy", 64'(busy), 64'd1);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst busy", 64'(busy), 64'd0);
    chk("async_rst done", 64'(done), 64'd0);
    chk("async_rst N", 64'(N), 64'd0);
    chk("async_rst exact", 64'(exact), 64'd0);
    @(posedge clk); #4;
    rst = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (done || busy) bad = 1'b1;
    end
    chk("post_rst no_done", 64'(bad), 64'd0);
    run_req("f24", 64'd24, 0, '0);

    for (int i = 0; i < 40; i++) begin
      r = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0: begin
          idx = $urandom_range(1, 20);
          r   = fact[idx][63:0];
        end
        1: r = r >> $urandom_range(0, 63);
        2: begin
          idx = $urandom_range(2, 20);
          r   = fact[idx][63:0] - 64'd1;
        end
        default: ;
      endcase
      run_req("rand", r, 0, '0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
